// File: rtl/quad_emitter.sv
// -----------------------------------------------------------------------------
// quad_emitter
//
// Turns single-cycle step requests into a quadrature (A/B) waveform, one edge
// per qualifying tick. Requests are queued in a signed pending counter
// (positive = up steps, negative = down steps) so opposing requests cancel.
// A started step always runs to completion in the direction latched at its
// start, and finishes back on the detent state (A,B)=11.
//
// Parameters
//   PEND_W          pending counter width; saturates at +/-(2^(PEND_W-1)-1)
//   EDGES_PER_STEP  quadrature edges per step (multiple of 4, >= 4)
//   TICKS_PER_EDGE  tick strobes needed per emitted edge (>= 1)
//
// Ports
//   clk        clock, all logic on rising edge
//   rst        asynchronous active-high reset
//   tick       single-cycle rate strobe
//   step_up    single-cycle request for one up step
//   step_down  single-cycle request for one down step
//   A, B       registered quadrature outputs, rest at 11
//   busy       high while a step is partially emitted
//   step_done  one-cycle pulse on the edge that completes a step
//   overflow   one-cycle pulse when a request is dropped on saturation
//   pending    signed count of queued steps not yet started
// -----------------------------------------------------------------------------
module quad_emitter #(
  parameter int PEND_W         = 5,
  parameter int EDGES_PER_STEP = 4,
  parameter int TICKS_PER_EDGE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic                     step_up,
  input  logic                     step_down,
  output logic                     A,
  output logic                     B,
  output logic                     busy,
  output logic                     step_done,
  output logic                     overflow,
  output logic signed [PEND_W-1:0] pending
);

  localparam int TCW = (TICKS_PER_EDGE > 1) ? $clog2(TICKS_PER_EDGE) : 1;
  localparam int ELW = (EDGES_PER_STEP > 1) ? $clog2(EDGES_PER_STEP) : 1;
  localparam int PEND_MAX_I = (1 << (PEND_W - 1)) - 1;

  // Pending arithmetic is done one bit wider so the saturation test can see
  // the out-of-range result before it wraps.
  localparam logic signed [PEND_W:0] PEND_MAX = (PEND_W + 1)'(PEND_MAX_I);
  localparam logic signed [PEND_W:0] PEND_MIN = -PEND_MAX;
  localparam logic signed [PEND_W:0] PEND_ONE = (PEND_W + 1)'(1);

  localparam logic [TCW-1:0] TICK_LAST   = TCW'(TICKS_PER_EDGE - 1);
  localparam logic [ELW-1:0] EDGES_FIRST = ELW'(EDGES_PER_STEP - 1);

  typedef enum logic {
    ST_IDLE,
    ST_STEP
  } state_t;

  state_t                    state_reg, state_next;
  logic                      a_reg, a_next;
  logic                      b_reg, b_next;
  logic                      step_done_reg, step_done_next;
  logic                      overflow_reg, overflow_next;
  logic                      dir_reg, dir_next;        // 1 = down
  logic signed [PEND_W-1:0]  pending_reg, pending_next;
  logic [TCW-1:0]            tick_cnt_reg, tick_cnt_next;
  logic [ELW-1:0]            edges_left_reg, edges_left_next;

  logic                      active;
  logic                      qual;
  logic                      start;
  logic                      advance;
  logic                      emit;
  logic                      emit_down;
  logic [ELW-1:0]            el_after;
  logic                      req_up;
  logic                      req_down;
  logic signed [PEND_W:0]    pend_ext;
  logic signed [PEND_W:0]    pend_base;
  logic signed [PEND_W:0]    pend_sum;

  always_comb begin
    state_next      = state_reg;
    a_next          = a_reg;
    b_next          = b_reg;
    step_done_next  = 1'b0;
    overflow_next   = 1'b0;
    dir_next        = dir_reg;
    pending_next    = pending_reg;
    tick_cnt_next   = tick_cnt_reg;
    edges_left_next = edges_left_reg;

    // The tick divider only runs while there is work to do, so an idle
    // emitter always waits a full TICKS_PER_EDGE ticks before its first edge.
    active  = (state_reg == ST_STEP) || (pending_reg != '0);
    qual    = tick && active && (tick_cnt_reg == TICK_LAST);
    // When idle, active already implies pending is non-zero.
    start   = qual && (state_reg == ST_IDLE);
    advance = qual && (state_reg == ST_STEP);
    emit    = start || advance;

    // A new step takes its direction from the sign of the queue; a running
    // step keeps the direction it latched.
    emit_down = start ? pending_reg[PEND_W-1] : dir_reg;
    el_after  = start ? EDGES_FIRST : (edges_left_reg - ELW'(1));

    if (!active) begin
      tick_cnt_next = '0;
    end else if (qual) begin
      tick_cnt_next = '0;
    end else if (tick) begin
      tick_cnt_next = tick_cnt_reg + TCW'(1);
    end

    if (emit) begin
      if (start) begin
        dir_next = emit_down;
      end
      edges_left_next = el_after;

      // Up walks 11->01->00->10: when A==B the next up edge moves A, else B.
      // Down is the mirror image, so the choice of channel simply inverts.
      if ((a_reg == b_reg) != emit_down) begin
        a_next = ~a_reg;
      end else begin
        b_next = ~b_reg;
      end

      if ((el_after == '0) && a_next && b_next) begin
        state_next     = ST_IDLE;
        step_done_next = 1'b1;
      end else begin
        state_next     = ST_STEP;
      end
    end

    // Queue update: the start consumption is applied first, so a request
    // arriving in the same cycle as a start sees the freed slot.
    pend_ext  = {pending_reg[PEND_W-1], pending_reg};
    pend_base = pend_ext;
    if (start) begin
      pend_base = emit_down ? (pend_ext + PEND_ONE) : (pend_ext - PEND_ONE);
    end

    req_up   = step_up & ~step_down;
    req_down = step_down & ~step_up;

    pend_sum = pend_base;
    if (req_up) begin
      pend_sum = pend_base + PEND_ONE;
    end else if (req_down) begin
      pend_sum = pend_base - PEND_ONE;
    end

    if ((req_up && (pend_sum > PEND_MAX)) || (req_down && (pend_sum < PEND_MIN))) begin
      overflow_next = 1'b1;
      pending_next  = pend_base[PEND_W-1:0];
    end else begin
      pending_next  = pend_sum[PEND_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      a_reg          <= 1'b1;
      b_reg          <= 1'b1;
      step_done_reg  <= 1'b0;
      overflow_reg   <= 1'b0;
      dir_reg        <= 1'b0;
      pending_reg    <= '0;
      tick_cnt_reg   <= '0;
      edges_left_reg <= '0;
    end else begin
      state_reg      <= state_next;
      a_reg          <= a_next;
      b_reg          <= b_next;
      step_done_reg  <= step_done_next;
      overflow_reg   <= overflow_next;
      dir_reg        <= dir_next;
      pending_reg    <= pending_next;
      tick_cnt_reg   <= tick_cnt_next;
      edges_left_reg <= edges_left_next;
    end
  end

  assign A         = a_reg;
  assign B         = b_reg;
  assign busy      = (state_reg == ST_STEP);
  assign step_done = step_done_reg;
  assign overflow  = overflow_reg;
  assign pending   = pending_reg;

endmodule

// File: doc/quad_emitter.md
QUAD_EMITTER -- requirements
Module: quad_emitter

Interface
REQ-001 Parameter PEND_W, default 5: pending-step counter width; signed range is ±(2^(PEND_W-1)-1), i.e. ±15 by default.
REQ-002 Parameter EDGES_PER_STEP, default 4: quadrature edges per step; the value SHALL be a multiple of 4 and at least 4.
REQ-003 Parameter TICKS_PER_EDGE, default 1: number of tick strobes per emitted edge; the value SHALL be at least 1.
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 tick  input  1  single-cycle rate strobe, e.g. from the divider.
REQ-007 step_up  input  1  single-cycle request for one step in the up direction.
REQ-008 step_down  input  1  single-cycle request for one step in the down direction.
REQ-009 A  output  1  quadrature channel A, registered.
REQ-010 B  output  1  quadrature channel B, registered.
REQ-011 busy  output  1  high while a step is partially emitted.
REQ-012 step_done  output  1  one-cycle pulse when a step completes.
REQ-013 overflow  output  1  one-cycle pulse when a request is dropped.
REQ-014 pending  output  PEND_W  signed count of queued, not-yet-started steps.

Function
REQ-015 The phase sequence (A,B) SHALL be: up = 11→01→00→10→11; down = the exact reverse. Exactly one channel changes per edge.
REQ-016 The detent (rest) state SHALL be (A,B)=11. A and B SHALL only change on an emitted edge.
REQ-017 Request queueing:
- step_up alone: pending+1.
- step_down alone: pending−1.
- step_up and step_down in the same cycle: no change, no overflow.
REQ-018 Saturation: a request that would push pending beyond ±max SHALL be dropped, with overflow=1 for exactly that cycle.
REQ-019 tick_cnt SHALL count tick strobes while busy=1 or pending≠0, and is held at 0 otherwise. A qualifying tick is a tick with tick_cnt==TICKS_PER_EDGE−1; on it, tick_cnt returns to 0.
REQ-020 Step start: on a qualifying tick with busy=0 and pending≠0:
- latch dir = sign(pending);
- move pending one toward zero;
- emit the first edge;
- set edges_left = EDGES_PER_STEP−1;
- busy=1 (unless EDGES_PER_STEP edges are already complete).
REQ-021 Mid-step: each qualifying tick with busy=1 SHALL emit one edge in the latched dir and decrement edges_left. A new request never alters an in-progress step's direction.
REQ-022 Step completion: on the edge that returns (A,B) to 11 with edges_left reaching 0:
- busy←0;
- step_done=1 for that same cycle.
The next step may start no earlier than the next qualifying tick.
REQ-023 Latency: A/B, busy and step_done SHALL update on the clk edge that samples the qualifying tick (1-cycle registered latency).
REQ-024 A request and a step-start consumption in the same cycle SHALL both apply. Example: pending=+15, step_up, and start → pending stays +15, no overflow.
REQ-025 Opposing queued requests SHALL net out in pending. Example: +3 followed by 3× step_down → 0, and no step starts.
REQ-026 A tick while idle with pending=0 SHALL have no effect.

Reset
REQ-027 rst=1 SHALL asynchronously force:
- A=1, B=1;
- busy=0, step_done=0, overflow=0;
- pending=0, tick_cnt=0, edges_left=0, dir=up.
REQ-028 Reset mid-step SHALL abandon the step and the queue; outputs return to 11 immediately, without completing the remaining edges.
REQ-029 After rst deasserts, the first edge SHALL occur no earlier than the first qualifying tick.

Verification
REQ-030 Defaults, one step_up, tick every 10 cycles → (A,B)=01,00,10,11 on 4 successive ticks. busy high after the 1st edge until the 4th; step_done on the 4th edge; pending 1→0 at the 1st edge.
REQ-031 One step_down, same setup → (A,B)=10,00,01,11; step_done once.
REQ-032 TICKS_PER_EDGE=3 → edges only on every 3rd tick; 12 ticks produce one full step.
REQ-033 Saturation: 16 step_up pulses with no tick → pending=+15, overflow exactly once (on the 16th). Same-cycle step_up and step_down → pending unchanged, no overflow.
REQ-034 Direction latch: step_up queued, then step_down pulsed after the 2nd edge → up step completes (01,00,10,11), then a full down step follows; pending ends at 0.
REQ-035 Reset mid-step: rst asserted after the 2nd edge with pending=+2 → A=B=1 the same cycle, pending=0, busy=0; no edges after release until new requests arrive.
